uart_tx: RTL and testbench

Byte-serialising UART transmitter that consumes the single-cycle baud `tick` produced by `baud_generator` and drives the serial `tx` line. It accepts parallel bytes over a valid/ready handshake into a one-entry holding register, so a second byte can queue while a frame is on the wire. Frames are start bit, data bits LSB first, optional parity bit, then stop bits. The parent instantiates `uart_tx` next to `baud_generator`, with both on the same clock.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx.sv | 142 ++++++++++++++
 tb/tb_uart_tx.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and parity-mode constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a tick-paced frame shifter.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned CNT_W = 4;

    tx_state_t              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic                   hold_valid_q, hold_valid_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   parity_q, parity_d;
    logic                   tx_d, tx_ready_d, busy_d;
    logic                   load_c;

    // State and datapath registers; reset forces the line idle at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            parity_q     <= 1'b0;
            tx           <= 1'b1;
            tx_ready     <= 1'b1;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            parity_q     <= parity_d;
            tx           <= tx_d;
            tx_ready     <= tx_ready_d;
            busy         <= busy_d;
        end
    end

    // Next-state, line level and holding-register control; all moves gated by tick.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        parity_d     = parity_q;
        tx_d         = tx;
        load_c       = 1'b0;

        // tx_ready is low whenever the holder is full, so accept and load never collide.
        if (tx_valid && tx_ready) begin
            hold_d       = tx_data;
            hold_valid_d = 1'b1;
        end

        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (hold_valid_q) begin
                        load_c  = 1'b1;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        tx_d = 1'b1;
                    end
                end
                ST_START: begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        if (PARITY_MODE != PAR_NONE) begin
                            tx_d    = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = ST_STOP;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_STOP;
                end
                ST_STOP: begin
                    if (32'(stop_cnt_q) < STOP_BITS - 1) begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end else if (hold_valid_q) begin
                        // Chain straight into the next start bit with no idle gap.
                        load_c  = 1'b1;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (load_c) begin
            shift_d      = hold_q;
            parity_d     = (^hold_q) ^ (PARITY_MODE == PAR_ODD);
            hold_valid_d = 1'b0;
        end

        tx_ready_d = !hold_valid_d;
        busy_d     = (state_d != ST_IDLE) || hold_valid_d;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four configurations share clock, reset and a 1-in-16 tick.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int unsigned TICK_PER = 16;

    typedef struct {
        logic [11:0] bits;   // line level per bit period, start bit in bit 0
        int          len;    // bit periods in the frame
        bit          b2b;    // start must follow previous frame with no idle clocks
        bit          abort;  // frame is expected to be cut short by reset
    } frame_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tick  = 1'b0;

    logic [7:0] data  [4];
    logic       valid [4];
    logic       ready [4];
    logic       busy_w[4];
    logic       tx_w  [4];

    logic tx0, tx1, tx2, tx3;
    logic rdy0, rdy1, rdy2, rdy3;
    logic bsy0, bsy1, bsy2, bsy3;

    frame_t exp_q[4][$];
    int     prev_end[4];
    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;

    uart_tx #(.DATA_BITS(8), .PARITY_MODE(PAR_NONE), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .tick(tick), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(rdy0), .tx(tx0), .busy(bsy0));
    uart_tx #(.DATA_BITS(8), .PARITY_MODE(PAR_EVEN), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .tick(tick), .tx_data(data[1]), .tx_valid(valid[1]),
        .tx_ready(rdy1), .tx(tx1), .busy(bsy1));
    uart_tx #(.DATA_BITS(8), .PARITY_MODE(PAR_ODD), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(reset), .tick(tick), .tx_data(data[2]), .tx_valid(valid[2]),
        .tx_ready(rdy2), .tx(tx2), .busy(bsy2));
    uart_tx #(.DATA_BITS(8), .PARITY_MODE(PAR_NONE), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .reset(reset), .tick(tick), .tx_data(data[3]), .tx_valid(valid[3]),
        .tx_ready(rdy3), .tx(tx3), .busy(bsy3));

    always_comb begin
        tx_w[0] = tx0;  tx_w[1] = tx1;  tx_w[2] = tx2;  tx_w[3] = tx3;
        ready[0] = rdy0; ready[1] = rdy1; ready[2] = rdy2; ready[3] = rdy3;
        busy_w[0] = bsy0; busy_w[1] = bsy1; busy_w[2] = bsy2; busy_w[3] = bsy3;
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Baud strobe: one clock high out of every 16, changed on the falling edge.
    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            tick = (c == TICK_PER - 1);
            c = (c + 1) % TICK_PER;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic frame_t frame_of(input logic [7:0] d, input int par, input int stops,
                                        input bit b2b, input bit ab);
        frame_t f;
        int     n;
        f.bits = '0;
        for (int i = 0; i < 8; i++) f.bits[1 + i] = d[i];
        n = 9;
        if (par != 0) begin
            f.bits[n] = (^d) ^ (par == 2);
            n++;
        end
        for (int s = 0; s < stops; s++) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.len   = n;
        f.b2b   = b2b;
        f.abort = ab;
        return f;
    endfunction

    // Watches one tx line: captures each frame, pops its expectation and compares.
    task automatic monitor(input int id);
        logic        s[192];
        logic [11:0] got;
        frame_t      e;
        int          start, hold_bad;
        bit          aborted, have;
        forever begin
            @(negedge clk);
            if (reset || tx_w[id] !== 1'b0) continue;
            start = cyc;
            have  = exp_q[id].size() > 0;
            if (have) begin
                e = exp_q[id].pop_front();
            end else begin
                e = frame_of(8'h00, 0, 1, 1'b0, 1'b0);
                checks++;
                failures++;
                $display("FAIL unexpected_frame dut%0d: got start bit at cycle %0d, expected idle line", id, cyc);
            end
            aborted = 1'b0;
            for (int j = 0; j < 16 * e.len; j++) begin
                if (j > 0) @(negedge clk);
                if (reset) begin
                    aborted = 1'b1;
                    break;
                end
                s[j] = tx_w[id];
            end
            if (have) begin
                check($sformatf("frame_abort_dut%0d", id), 32'(aborted), 32'(e.abort));
                if (!aborted) begin
                    got      = '0;
                    hold_bad = 0;
                    for (int k = 0; k < e.len; k++) got[k] = s[16 * k];
                    for (int j = 0; j < 16 * e.len; j++)
                        if (s[j] !== s[16 * (j / 16)]) hold_bad++;
                    check($sformatf("frame_bits_dut%0d", id), 32'(got), 32'(e.bits));
                    check($sformatf("bit_hold_dut%0d", id), 32'(hold_bad), 32'd0);
                    if (e.b2b)
                        check($sformatf("b2b_gap_start_dut%0d", id), 32'(start), 32'(prev_end[id]));
                end
            end
            if (!aborted) prev_end[id] = start + 16 * e.len;
        end
    endtask

    task automatic send(input int id, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready[id] && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!ready[id]) begin
            check($sformatf("send_ready_timeout_dut%0d", id), 32'(ready[id]), 32'd1);
            return;
        end
        data[id]  = d;
        valid[id] = 1'b1;
        @(negedge clk);
        valid[id] = 1'b0;
        check($sformatf("ready_drop_after_accept_dut%0d", id), 32'(ready[id]), 32'd0);
    endtask

    task automatic wait_idle(input int id);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_w[id] && n < 800) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_busy_dut%0d", id), 32'(busy_w[id]), 32'd0);
        repeat (2) @(negedge clk);
        check($sformatf("frames_seen_dut%0d", id), 32'(exp_q[id].size()), 32'd0);
    endtask

    task automatic watch_quiet(input string name, input int clocks);
        int bad;
        bad = 0;
        for (int k = 0; k < clocks; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0) bad++;
        end
        check(name, 32'(bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by cycle %0d, expected $finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int     t0, n;
        logic   prev_tx;
        frame_t f;

        for (int i = 0; i < 4; i++) begin
            valid[i]    = 1'b0;
            data[i]     = 8'h00;
            prev_end[i] = 0;
        end
        fork
            monitor(0);
            monitor(1);
            monitor(2);
            monitor(3);
        join_none

        // Reset state, then five quiet ticks.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_tx_dut%0d", i), 32'(tx_w[i]), 32'd1);
            check($sformatf("reset_ready_dut%0d", i), 32'(ready[i]), 32'd1);
            check($sformatf("reset_busy_dut%0d", i), 32'(busy_w[i]), 32'd0);
        end
        reset = 1'b0;
        watch_quiet("idle_after_reset", 5 * TICK_PER);

        // 0xA5 8N1: levels 0,1,0,1,0,0,1,0,1,1.
        f = '{bits: 12'h34A, len: 10, b2b: 1'b0, abort: 1'b0};
        exp_q[0].push_back(f);
        send(0, 8'hA5);
        wait_idle(0);

        // Back-to-back 0x00 then 0xFF.
        exp_q[0].push_back(frame_of(8'h00, 0, 1, 1'b0, 1'b0));
        exp_q[0].push_back(frame_of(8'hFF, 0, 1, 1'b1, 1'b0));
        send(0, 8'h00);
        send(0, 8'hFF);
        n = 0;
        prev_tx = tx_w[0];
        @(negedge clk);
        while (!ready[0] && n < 400) begin
            prev_tx = tx_w[0];
            @(negedge clk);
            n++;
        end
        check("ready_rise_dut0", 32'(ready[0]), 32'd1);
        check("ready_rise_at_start_bit", 32'({prev_tx, tx_w[0]}), 32'b10);
        wait_idle(0);

        // 0x07 even parity (bit 1) and odd parity (bit 0), 11-tick frames.
        f = '{bits: 12'h60E, len: 11, b2b: 1'b0, abort: 1'b0};
        exp_q[1].push_back(f);
        f = '{bits: 12'h40E, len: 11, b2b: 1'b0, abort: 1'b0};
        exp_q[2].push_back(f);
        fork
            send(1, 8'h07);
            send(2, 8'h07);
        join
        fork
            wait_idle(1);
            wait_idle(2);
        join

        // Two stop bits with a queued second byte.
        exp_q[3].push_back(frame_of(8'h81, 0, 2, 1'b0, 1'b0));
        exp_q[3].push_back(frame_of(8'h42, 0, 2, 1'b1, 1'b0));
        send(3, 8'h81);
        send(3, 8'h42);
        wait_idle(3);

        // Mid-frame reset during data bit 3 of 0x5A with 0x11 waiting in the holder.
        exp_q[0].push_back(frame_of(8'h5A, 0, 1, 1'b0, 1'b1));
        send(0, 8'h5A);
        n = 0;
        while (tx_w[0] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("start_bit_5a", 32'(tx_w[0]), 32'd0);
        t0 = cyc;
        send(0, 8'h11);
        while (cyc < t0 + 72) @(negedge clk);
        check("busy_before_reset", 32'(busy_w[0]), 32'd1);
        reset = 1'b1;
        #1;
        check("midreset_tx", 32'(tx_w[0]), 32'd1);
        check("midreset_ready", 32'(ready[0]), 32'd1);
        check("midreset_busy", 32'(busy_w[0]), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        watch_quiet("quiet_after_midreset", 5 * TICK_PER);
        check("abort_frame_consumed", 32'(exp_q[0].size()), 32'd0);
        exp_q[0].push_back(frame_of(8'h3C, 0, 1, 1'b0, 1'b0));
        send(0, 8'h3C);
        wait_idle(0);

        for (int i = 0; i < 4; i++)
            check($sformatf("final_queue_empty_dut%0d", i), 32'(exp_q[i].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
